// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo write arbiter.
// Contents: state enum, stat/beat counter widths, idx_w() index width.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;
    localparam int BEAT_W = 8;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: rotating-priority encoder, search starts at rr_ptr.
// Ports: req (in), rr_ptr (in), grant one-hot / idx / any (out).
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

    logic [IW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so rr_ptr + k cannot overflow before the wrap.
            pos = {1'b0, rr_ptr} + (IW+1)'(k);
            if (pos >= NR) begin
                pos = pos - NR;
            end
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                grant[pos[IW-1:0]] = 1'b1;
                idx                = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one fifo write port, burst lock.
// Ports: clock, reset, req, req_data, ack, fifo_write, fifo_datain,
//   fifo_full, owner, locked; stat_grants/stat_stalls with FIFO_ARB_STATS_EN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        fifo_write,
    output logic [DATA_W-1:0]           fifo_datain,
    input  logic                        fifo_full,
    output logic [idx_w(NUM_REQ)-1:0]   owner,
    output logic                        locked
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   stat_grants,
    output logic [STAT_W-1:0]           stat_stalls
`endif
);

    localparam int IW = idx_w(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    arb_state_t         state;
    logic [IW-1:0]      rr_ptr;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      win;
    logic               pick_any;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // During a burst only the owner is eligible; nothing is granted in reset.
    always_comb begin
        grant = '0;
        win   = owner;
        if (!reset) begin
            if (state == ARB_BURST) begin
                if (req[owner]) begin
                    grant[owner] = 1'b1;
                end
            end else if (pick_any) begin
                grant = pick_grant;
                win   = pick_idx;
            end
        end
    end

    assign ack        = fifo_full ? '0 : grant;
    assign fifo_write = |ack;
    assign locked     = (state == ARB_BURST);

    always_comb begin
        fifo_datain = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fifo_datain = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (fifo_write) begin
                        owner    <= win;
                        beat_cnt <= BEAT_W'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr <= next_idx(win);
                        end else begin
                            state <= ARB_BURST;
                        end
                    end
                end
                ARB_BURST: begin
                    // A dropped request releases the lock even while full.
                    if (!req[owner]) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_idx(owner);
                    end else if (fifo_write) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_idx(owner);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i] && stat_grants[i*STAT_W +: STAT_W] != '1) begin
                    stat_grants[i*STAT_W +: STAT_W] <=
                        stat_grants[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if (|req && fifo_full && stat_stalls != '1) begin
                stat_stalls <= stat_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, directed corners, random vs model.
// Models a 6-entry fifo on the write side; checks stats if enabled.
module tb_fifo_write_arbiter;

    localparam int DW  = 10;
    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int FSZ = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [39:0] req_data = '0;
    logic [3:0]  ack;
    logic        fifo_write;
    logic [9:0]  fifo_datain;
    logic        fifo_full = 1'b0;
    logic [1:0]  owner;
    logic        locked;

    logic [3:0]  rr_ack;
    logic        rr_write;
    logic [9:0]  rr_din;
    logic        rr_full = 1'b0;
    logic [1:0]  rr_owner;
    logic        rr_locked;

`ifdef FIFO_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_stalls;
    logic [63:0] rr_sg;
    logic [15:0] rr_ss;
`endif

    always #5 clock = ~clock;

    fifo_write_arbiter #(
        .DATA_W (DW), .NUM_REQ (NR), .MAX_BURST (MB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .fifo_write  (fifo_write),
        .fifo_datain (fifo_datain),
        .fifo_full   (fifo_full),
        .owner       (owner),
        .locked      (locked)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls)
`endif
    );

    fifo_write_arbiter #(
        .DATA_W (DW), .NUM_REQ (NR), .MAX_BURST (1)
    ) dut_rr (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (rr_ack),
        .fifo_write  (rr_write),
        .fifo_datain (rr_din),
        .fifo_full   (rr_full),
        .owner       (rr_owner),
        .locked      (rr_locked)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_grants (rr_sg),
        .stat_stalls (rr_ss)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] ack;
        logic [1:0] own;
        logic       lck;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         m_locked = 0;
    int         m_owner  = 0;
    int         m_ptr    = 0;
    int         m_beats  = 0;
    int         m_grants [4] = '{0, 0, 0, 0};
    int         m_stalls = 0;
    logic [9:0] fq [$];
    bit         use_fifo = 0;
    logic [3:0] rr_ack_s;
    logic [9:0] rr_din_s;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] a);
        for (int i = 0; i < NR; i++) begin
            if (a[i]) return i;
        end
        return 0;
    endfunction

    // Grant from the rules: owner only while locked, else first
    // requester at or after the pointer, wrapping around.
    function automatic logic [3:0] exp_grant();
        if (reset) return 4'b0;
        if (m_locked) return req[m_owner] ? 4'(1 << m_owner) : 4'b0;
        for (int k = 0; k < NR; k++) begin
            int j = (m_ptr + k) % NR;
            if (req[j]) return 4'(1 << j);
        end
        return 4'b0;
    endfunction

    task automatic model_edge(input logic [3:0] a);
        if (reset) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
            m_grants = '{0, 0, 0, 0};
            m_stalls = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (a[i] && m_grants[i] < 65535) m_grants[i]++;
            end
            if (|req && fifo_full && m_stalls < 65535) m_stalls++;
            if (!m_locked) begin
                if (a != 0) begin
                    m_owner = idx_of(a);
                    m_beats = 1;
                    if (MB == 1) m_ptr = (m_owner + 1) % NR;
                    else m_locked = 1;
                end
            end else if (!req[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % NR;
            end else if (a != 0) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % NR;
                end
            end
        end
    endtask

    // One clock: called at negedge with inputs driven, returns at negedge.
    task automatic tick(input string tag, output logic [3:0] a_s);
        logic [3:0]  g;
        logic [3:0]  a;
        logic        wr;
        logic [9:0]  din;
        logic [63:0] eg;
        if (use_fifo) fifo_full = (fq.size() >= FSZ);
        #1;
        g = exp_grant();
        a = fifo_full ? 4'b0 : g;
        check($sformatf("%s ack", tag), 64'(ack), 64'(a));
        check($sformatf("%s wr", tag), 64'(fifo_write), 64'(|a));
        if (a != 0) begin
            check($sformatf("%s din", tag), 64'(fifo_datain),
                  64'(req_data[idx_of(a)*DW +: DW]));
        end
        a_s      = ack;
        wr       = fifo_write;
        din      = fifo_datain;
        rr_ack_s = rr_ack;
        rr_din_s = rr_din;
        @(posedge clock);
        if (wr) fq.push_back(din);
        model_edge(a);
        #1;
        check($sformatf("%s owner", tag), 64'(owner), 64'(m_owner));
        check($sformatf("%s locked", tag), 64'(locked), 64'(m_locked));
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NR; i++) eg[i*16 +: 16] = 16'(m_grants[i]);
        check($sformatf("%s grants", tag), stat_grants, eg);
        check($sformatf("%s stalls", tag), 64'(stat_stalls),
              64'(m_stalls));
`else
        eg = '0;
`endif
        @(negedge clock);
    endtask

    task automatic do_reset();
        logic [3:0] s;
        reset = 1'b1;
        req   = '0;
        tick("rst", s);
        reset = 1'b0;
    endtask

    initial begin
        vec_t       tbl [9];
        logic [3:0] s;
        logic [9:0] exp_q [6];
        logic [3:0] rr_exp_a [5];
        logic [9:0] rr_exp_d [5];
        bit         pend [4];
        logic [9:0] w [4];

        tbl[0] = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 4'h3, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[3] = '{1'b0, 4'h3, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[4] = '{1'b0, 4'h3, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[5] = '{1'b0, 4'h3, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[6] = '{1'b0, 4'h3, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[7] = '{1'b0, 4'h3, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[8] = '{1'b0, 4'h3, 1'b1, 4'b0000, 2'd1, 1'b1};
        exp_q  = '{10'd1, 10'd1, 10'd1, 10'd1, 10'd2, 10'd2};
        rr_exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_exp_d = '{10'd11, 10'd22, 10'd33, 10'd44, 10'd11};

        req_data = {10'd0, 10'd0, 10'd2, 10'd1};
        @(negedge clock);

        // Reset and burst, table driven.
        fq.delete();
        for (int i = 0; i < 9; i++) begin
            reset     = tbl[i].rst;
            req       = tbl[i].req;
            fifo_full = tbl[i].full;
            tick($sformatf("vec%0d", i), s);
            check($sformatf("vec%0d tbl ack", i), 64'(s), 64'(tbl[i].ack));
            check($sformatf("vec%0d tbl own", i), 64'(owner),
                  64'(tbl[i].own));
            check($sformatf("vec%0d tbl lck", i), 64'(locked),
                  64'(tbl[i].lck));
        end
        check("burst fifo count", 64'(fq.size()), 64'(6));
        for (int i = 0; i < 6 && i < fq.size(); i++) begin
            check($sformatf("burst dataout%0d", i), 64'(fq[i]),
                  64'(exp_q[i]));
        end

        // Pure round-robin instance.
        fifo_full = 1'b0;
        do_reset();
        req_data = {10'd44, 10'd33, 10'd22, 10'd11};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick($sformatf("rr%0d", k), s);
            check($sformatf("rr%0d ack", k), 64'(rr_ack_s),
                  64'(rr_exp_a[k]));
            check($sformatf("rr%0d din", k), 64'(rr_din_s),
                  64'(rr_exp_d[k]));
        end

        // Full stall mid-burst.
        do_reset();
        fq.delete();
        repeat (4) fq.push_back(10'd0);
        use_fifo = 1;
        req_data = {10'd0, 10'd0, 10'd6, 10'd5};
        req = 4'b0001;
        tick("t4a", s);
        check("t4 first ack", 64'(s), 64'(4'b0001));
        tick("t4b", s);
        req = 4'b0011;
        tick("t4c", s);
        check("t4 full ack", 64'(s), 64'(0));
        check("t4 full lock", 64'(locked), 64'(1));
        tick("t4d", s);
        void'(fq.pop_front());
        tick("t4e", s);
        check("t4 resume ack", 64'(s), 64'(4'b0001));
        void'(fq.pop_front());
        tick("t4f", s);
        check("t4 last ack", 64'(s), 64'(4'b0001));
        check("t4 unlock", 64'(locked), 64'(0));
        void'(fq.pop_front());
        tick("t4g", s);
        check("t4 next ack", 64'(s), 64'(4'b0010));

        // Early release.
        fq.delete();
        do_reset();
        req_data = {10'd0, 10'd9, 10'd0, 10'd7};
        req = 4'b0101;
        tick("t5a", s);
        check("t5 first ack", 64'(s), 64'(4'b0001));
        req = 4'b0100;
        tick("t5b", s);
        check("t5 drop ack", 64'(s), 64'(0));
        check("t5 unlock", 64'(locked), 64'(0));
        tick("t5c", s);
        check("t5 next ack", 64'(s), 64'(4'b0100));

        // Reset mid-burst.
        fq.delete();
        do_reset();
        req = 4'b0001;
        repeat (3) tick("t6", s);
        check("t6 locked", 64'(locked), 64'(1));
`ifdef FIFO_ARB_STATS_EN
        check("t6 grants0", 64'(stat_grants[15:0]), 64'(3));
`endif
        reset = 1'b1;
        req = 4'b0010;
        tick("t6r", s);
        check("t6 rst ack", 64'(s), 64'(0));
        check("t6 rst lock", 64'(locked), 64'(0));
        check("t6 rst owner", 64'(owner), 64'(0));
`ifdef FIFO_ARB_STATS_EN
        check("t6 rst grants", stat_grants, 64'(0));
        check("t6 rst stalls", 64'(stat_stalls), 64'(0));
`endif
        reset = 1'b0;
        req = 4'b0011;
        tick("t6n", s);
        check("t6 after ack", 64'(s), 64'(4'b0001));

        // Random traffic against the model.
        fq.delete();
        do_reset();
        pend = '{0, 0, 0, 0};
        w    = '{10'd0, 10'd0, 10'd0, 10'd0};
        for (int c = 0; c < 600; c++) begin
            if (fq.size() > 0 && $urandom_range(1, 0) == 1) begin
                void'(fq.pop_front());
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(2, 0) == 0) begin
                    pend[i] = 1;
                    w[i] = 10'($urandom);
                end else if (pend[i] && $urandom_range(19, 0) == 0) begin
                    pend[i] = 0;
                end
                req[i] = pend[i];
                req_data[i*DW +: DW] = w[i];
            end
            reset = ($urandom_range(99, 0) == 0);
            tick("rnd", s);
            for (int i = 0; i < NR; i++) begin
                if (s[i]) pend[i] = 0;
            end
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
